// File: rtl/add_serial_feeder.sv
// add_serial_feeder: operand FIFO and sequencer for the add_serial bit-serial adder.
// It buffers operand pairs, performs the en kick/launch handshake, waits out the
// adder latency, and then presents each sum on a valid/ready result port.
// Optional build macro ADD_SERIAL_FEEDER_CHECK_EN: each FIFO entry also holds the
// expected sum, and a sticky o_err flags any capture that does not match it.
//
// state      | meaning
// F_IDLE     | waiting for an operand pair and a free result slot
// F_KICK     | en pulse that moves the adder from DONE back to IDLE
// F_LAUNCH   | en pulse the adder samples together with add_a/add_b
// F_WAIT     | counting down the adder latency
// F_CAPTURE  | latch add_out, pop the FIFO, raise res_valid
module add_serial_feeder #(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      DEPTH       = 4,
  parameter int unsigned      WAIT_CYCLES = 11,
  parameter logic [WIDTH-1:0] A_KEY       = '0,
  parameter logic [WIDTH-1:0] B_KEY       = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_a,
  input  logic [WIDTH-1:0] i_in_b,
  output logic [WIDTH-1:0] o_add_a,
  output logic [WIDTH-1:0] o_add_b,
  output logic             o_add_en,
  input  logic [WIDTH-1:0] i_add_out,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [WIDTH-1:0] o_res_data,
  output logic             o_busy,
`ifdef ADD_SERIAL_FEEDER_CHECK_EN
  output logic             o_err,
`endif
  output logic [15:0]      o_op_count
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned WCW = $clog2(WAIT_CYCLES + 1);

  typedef enum logic [2:0] {
    F_IDLE    = 3'd0,
    F_KICK    = 3'd1,
    F_LAUNCH  = 3'd2,
    F_WAIT    = 3'd3,
    F_CAPTURE = 3'd4
  } fstate_t;

  fstate_t          r_state;
  logic [WCW-1:0]   r_wait_cnt;
  logic             r_needs_kick;
  logic             r_res_valid;
  logic [WIDTH-1:0] r_res_data;
  logic [15:0]      r_op_count;
  logic [WIDTH-1:0] r_add_a;
  logic [WIDTH-1:0] r_add_b;

  logic [WIDTH-1:0] r_fifo_a [DEPTH];
  logic [WIDTH-1:0] r_fifo_b [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_push;
  logic w_pop;
  logic w_fifo_nempty;
  logic w_slot_free;

  assign w_fifo_nempty = (r_count != '0);
  assign o_in_ready    = (r_count != CW'(DEPTH));
  assign w_push        = i_in_valid && o_in_ready;
  assign w_pop         = (r_state == F_CAPTURE);
  // The held result may be leaving on this very edge, so a launch can overlap
  // its consumption without ever having two results outstanding.
  assign w_slot_free   = !r_res_valid || i_res_ready;

  assign o_add_a     = r_add_a;
  assign o_add_b     = r_add_b;
  assign o_add_en    = (r_state == F_KICK) || (r_state == F_LAUNCH);
  assign o_busy      = (r_state != F_IDLE);
  assign o_res_valid = r_res_valid;
  assign o_res_data  = r_res_data;
  assign o_op_count  = r_op_count;

`ifdef ADD_SERIAL_FEEDER_CHECK_EN
  logic [WIDTH-1:0] r_fifo_exp [DEPTH];
  logic             r_err;
  assign o_err = r_err;

  // Expected-sum storage alongside the operands; stale entries are never read.
  always_ff @(posedge i_clk) begin
    if (w_push) r_fifo_exp[r_wr_ptr] <= (i_in_a ^ A_KEY) + (i_in_b ^ B_KEY);
  end
`endif

  // Operand storage; no reset because only occupied entries are ever read.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_a[r_wr_ptr] <= i_in_a;
      r_fifo_b[r_wr_ptr] <= i_in_b;
    end
  end

  // FIFO pointers and occupancy; pops happen only at capture, never on empty.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered copy of the FIFO head driving the adder operand pins.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_add_a <= '0;
      r_add_b <= '0;
    end else if (w_fifo_nempty) begin
      r_add_a <= r_fifo_a[r_rd_ptr];
      r_add_b <= r_fifo_b[r_rd_ptr];
    end
  end

  // Sequencer FSM with result register, op counter and kick bookkeeping.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state      <= F_IDLE;
      r_wait_cnt   <= '0;
      r_needs_kick <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_data   <= '0;
      r_op_count   <= '0;
`ifdef ADD_SERIAL_FEEDER_CHECK_EN
      r_err        <= 1'b0;
`endif
    end else begin
      if (r_res_valid && i_res_ready) r_res_valid <= 1'b0;
      case (r_state)
        F_IDLE: begin
          if (w_fifo_nempty && w_slot_free) r_state <= r_needs_kick ? F_KICK : F_LAUNCH;
        end
        F_KICK: begin
          r_needs_kick <= 1'b0;
          r_state      <= F_LAUNCH;
        end
        F_LAUNCH: begin
          r_wait_cnt <= WCW'(WAIT_CYCLES - 1);
          r_state    <= F_WAIT;
        end
        F_WAIT: begin
          // Leave as the count reaches zero so the capture edge lands exactly
          // WAIT_CYCLES edges after the adder sampled the launch.
          r_wait_cnt <= r_wait_cnt - WCW'(1);
          if (r_wait_cnt <= WCW'(1)) r_state <= F_CAPTURE;
        end
        F_CAPTURE: begin
          r_res_data   <= i_add_out;
          r_res_valid  <= 1'b1;
          r_needs_kick <= 1'b1;
          r_op_count   <= r_op_count + 16'd1;
`ifdef ADD_SERIAL_FEEDER_CHECK_EN
          if (i_add_out != r_fifo_exp[r_rd_ptr]) r_err <= 1'b1;
`endif
          r_state <= F_IDLE;
        end
        default: r_state <= F_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_serial_feeder.sv
// Bench for add_serial_feeder: behavioural adder model, result scoreboard,
// and a linear sequence of directed steps.
module tb_add_serial_feeder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = 8'h00;
  logic [7:0] in_b = 8'h00;
  logic [7:0] add_a;
  logic [7:0] add_b;
  logic       add_en;
  logic [7:0] add_out;
  logic       res_valid;
  logic       res_ready = 1'b1;
  logic [7:0] res_data;
  logic       busy;
  logic [15:0] op_count;
`ifdef ADD_SERIAL_FEEDER_CHECK_EN
  logic       err;
`endif

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int en_in_busy = 0;

  logic [7:0] exp_q [$];
  int         en_log [$];
  int         res_log [$];
  logic [7:0] a_log [$];
  logic       res_prev = 1'b0;

  add_serial_feeder dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_a      (in_a),
    .i_in_b      (in_b),
    .o_add_a     (add_a),
    .o_add_b     (add_b),
    .o_add_en    (add_en),
    .i_add_out   (add_out),
    .o_res_valid (res_valid),
    .i_res_ready (res_ready),
    .o_res_data  (res_data),
    .o_busy      (busy),
`ifdef ADD_SERIAL_FEEDER_CHECK_EN
    .o_err       (err),
`endif
    .o_op_count  (op_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Adder model: plain add, with one deliberately corrupted sum.
  function automatic logic [7:0] model_sum(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h12 && b == 8'h34) return 8'h47;
    return a + b;
  endfunction

  typedef enum logic [1:0] {M_IDLE, M_BUSY, M_DONE} m_state_t;
  m_state_t   m_state = M_IDLE;
  logic [3:0] m_cnt   = 4'd0;
  logic [7:0] m_sum   = 8'h00;

  // Launch sampled in IDLE; out shows a wrong value until 10 edges later, so
  // a too-early capture is caught; DONE needs an en kick to return to IDLE.
  always @(posedge clk) begin
    if (!rst) begin
      m_state <= M_IDLE;
      add_out <= 8'h00;
      m_cnt   <= 4'd0;
    end else begin
      case (m_state)
        M_IDLE: if (add_en) begin
          m_sum   <= model_sum(add_a, add_b);
          add_out <= ~model_sum(add_a, add_b);
          m_cnt   <= 4'd0;
          m_state <= M_BUSY;
        end
        M_BUSY: begin
          if (add_en) en_in_busy <= en_in_busy + 1;
          if (m_cnt == 4'd9) begin
            add_out <= m_sum;
            m_state <= M_DONE;
          end else begin
            m_cnt <= m_cnt + 4'd1;
          end
        end
        M_DONE: if (add_en) m_state <= M_IDLE;
        default: m_state <= M_IDLE;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  // Monitor: scoreboard pops on handshake, plus en and result-rise logs.
  always @(negedge clk) begin
    if (rst) begin
      if (add_en) begin
        en_log.push_back(cyc);
        a_log.push_back(add_a);
      end
      if (res_valid && !res_prev) res_log.push_back(cyc);
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) chk("sb_extra_result", exp_q.size(), 1);
        else chk("sb_res_data", res_data, exp_q.pop_front());
      end
    end
    res_prev <= res_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (3) tick();
    exp_q.delete();
    en_log.delete();
    res_log.delete();
    a_log.delete();
    rst = 1'b1;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("push_in_ready", in_ready, 1);
    if (in_ready) exp_q.push_back(model_sum(a, b));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_results(input int cnt, input int limit);
    int n = 0;
    while (res_log.size() < cnt && n < limit) begin
      tick();
      n++;
    end
    chk("result_count", res_log.size(), cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset values
    rst = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_add_en", add_en, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_busy", busy, 0);
    chk("rst_op_count", op_count, 0);
`ifdef ADD_SERIAL_FEEDER_CHECK_EN
    chk("rst_err", err, 0);
`endif

    // Single op, no kick, 12-cycle latency from launch entry
    reset_dut();
    res_ready = 1'b1;
    push(8'h35, 8'h4A);
    wait_results(1, 60);
    chk("t1_en_cycles", en_log.size(), 1);
    if (en_log.size() >= 1 && res_log.size() >= 1) begin
      chk("t1_latency", res_log[0] - en_log[0], 12);
      chk("t1_add_a_at_launch", a_log[0], 8'h35);
    end
    chk("t1_res_data", res_data, 8'h7F);
    chk("t1_op_count", op_count, 1);

    // Two ops: second needs a kick, results 14 cycles apart
    reset_dut();
    push(8'hFF, 8'h01);
    push(8'h80, 8'h80);
    wait_results(2, 100);
    repeat (2) tick();
    chk("t2_en_cycles", en_log.size(), 3);
    if (en_log.size() == 3 && res_log.size() == 2) begin
      chk("t2_first_latency", res_log[0] - en_log[0], 12);
      chk("t2_kick_then_launch", en_log[2] - en_log[1], 1);
      chk("t2_second_latency", res_log[1] - en_log[2], 12);
      chk("t2_spacing", res_log[1] - res_log[0], 14);
    end
    chk("t2_res_data", res_data, 8'h00);
    chk("t2_op_count", op_count, 2);

    // Consumer stall: fill FIFO, refuse a fifth pair, hold first result
    reset_dut();
    res_ready = 1'b0;
    push(8'h01, 8'h02);
    push(8'h03, 8'h04);
    push(8'h05, 8'h06);
    push(8'h07, 8'h08);
    chk("t3_full_in_ready", in_ready, 0);
    in_a = 8'h09;
    in_b = 8'h0A;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (30) tick();
    chk("t3_held_valid", res_valid, 1);
    chk("t3_held_data", res_data, 8'h03);
    chk("t3_no_second_en", en_log.size(), 1);
    chk("t3_ready_after_pop", in_ready, 1);
    res_ready = 1'b1;
    n = 0;
    while ((op_count != 16'd4 || res_valid) && n < 200) begin
      tick();
      n++;
    end
    chk("t3_op_count", op_count, 4);
    chk("t3_res_valid_drained", res_valid, 0);
    chk("t3_sb_empty", exp_q.size(), 0);
    chk("t3_en_cycles", en_log.size(), 7);

    // Reset during F_WAIT discards the in-flight op
    reset_dut();
    push(8'h10, 8'h20);
    repeat (6) tick();
    chk("t4_busy_in_wait", busy, 1);
    chk("t4_en_low_in_wait", add_en, 0);
    rst = 1'b0;
    tick();
    chk("t4_res_valid", res_valid, 0);
    chk("t4_op_count", op_count, 0);
    chk("t4_busy", busy, 0);
    chk("t4_in_ready", in_ready, 1);
    chk("t4_add_a", add_a, 0);
    exp_q.delete();
    en_log.delete();
    res_log.delete();
    a_log.delete();
    rst = 1'b1;
    repeat (40) tick();
    chk("t4_no_stale_result", res_log.size(), 0);
    chk("t4_no_launch", en_log.size(), 0);
    chk("t4_op_count_after", op_count, 0);

    // Corrupted sum from the adder model
    reset_dut();
    push(8'h12, 8'h34);
    push(8'h01, 8'h01);
    wait_results(2, 100);
    repeat (2) tick();
    chk("t5_op_count", op_count, 2);
    chk("t5_last_data", res_data, 8'h02);
    chk("t5_sb_empty", exp_q.size(), 0);
`ifdef ADD_SERIAL_FEEDER_CHECK_EN
    chk("t5_err_sticky", err, 1);
`endif

    chk("model_en_while_busy", en_in_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
